iir_stream_ctrl: RTL and testbench
==================================

# iir_stream_ctrl

Frame sequencer for the fixed-coefficient IIR filter engine. On a start pulse it clears the engine state, streams `length` samples from a synchronous sample memory into the engine, and writes each engine output to result memory. It raises `done` when the frame is complete. It sits between the memory subsystem and the filter datapath, replacing free-running address counters with a start/busy/done frame protocol and read-side stall support.

## Interface
- `ADDR_W`, default 20: address and length width.
- `DATA_W`, default 16: sample width.
- `FLUSH_LEN`, default 5: zero samples appended per frame when flush is compiled in (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: frame request pulse; sampled only in IDLE.
- `base_raddr` in ADDR_W: first input sample address; captured at accepted start.
- `base_waddr` in ADDR_W: first output address; captured at accepted start.
- `length` in ADDR_W: input samples per frame; captured at accepted start; 0 is legal.
- `mem_wait` in 1: read stall; while high, no new read is issued.
- `ren` out 1: sample memory read enable.
- `raddr` out ADDR_W: read address.
- `rdata` in DATA_W: read data; valid exactly one cycle after `ren`.
- `f_clr` out 1: one-cycle engine state clear.
- `f_en` out 1: engine advance; engine consumes `f_din` and presents `f_dout` combinationally in the same cycle.
- `f_din` out DATA_W: engine input sample.
- `f_dout` in DATA_W: engine output.
- `wen` out 1: result write enable.
- `waddr` out ADDR_W: write address.
- `wdata` out DATA_W: write data (equals `f_dout`).
- `busy` out 1: high from the cycle after accepted start through the DONE cycle.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE → CLEAR on `start`.
  - CLEAR (1 cycle, `f_clr`=1) → RUN if `length`≠0, else DONE.
  - RUN → FLUSH, when the last write issues and the macro is defined.
  - RUN → DONE, when the last write issues and the macro is undefined.
  - FLUSH → DONE after FLUSH_LEN writes.
  - DONE (1 cycle, `done`=1) → IDLE.
- Read stage (RUN): while `rd_cnt`<`length` and `mem_wait`=0, assert `ren` with `raddr`=`base_raddr`+`rd_cnt`, then increment `rd_cnt`.
- Return stage: in the cycle after each `ren`:
  - `f_en`=1, `f_din`=`rdata`.
  - `wen`=1, `waddr`=`base_waddr`+`wr_cnt`, `wdata`=`f_dout`.
  - Increment `wr_cnt`.
  - This stage completes even if `mem_wait` is high; `mem_wait` blocks only new reads.
- Address arithmetic is modulo 2^ADDR_W; wrap past all-ones to 0 is silent.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Outputs not listed as active are 0. `raddr`/`waddr`/`f_din`/`wdata` are don't-care when their enable is low.

## Timing
- Reset values: `ren`, `f_clr`, `f_en`, `wen`, `busy`, `done` = 0; `raddr`, `waddr`, `f_din`, `wdata` = 0; state IDLE; counters 0.
- `rst` mid-frame aborts immediately; no further reads or writes; a new start is accepted in the first cycle after `rst` falls.
- Frame timeline, with `start` sampled in cycle 0 and no stalls:
  - `f_clr` in cycle 1.
  - `ren` in cycles 2..N+1.
  - `wen` in cycles 3..N+2.
  - `done` in cycle N+3 (without flush).
  - `busy` in cycles 1..N+3.
- Each stall cycle delays all later reads and writes by one cycle.
- `length`=0: `f_clr` in cycle 1, `done` in cycle 2, no reads or writes.

## Configuration
- `IIR_CTRL_FLUSH_EN` defined:
  - After the last input write, FLUSH issues FLUSH_LEN consecutive cycles of `f_en`=1, `f_din`=0, `wen`=1, `waddr` continuing from `base_waddr`+N.
  - No reads in FLUSH; `mem_wait` is ignored.
  - `done` moves to cycle N+FLUSH_LEN+3.
  - For `length`=0, CLEAR still goes straight to DONE (no flush).
- Undefined: the FLUSH state and its logic are absent.

## Structure
- Package `iir_ctrl_pkg`: state enum (IDLE, CLEAR, RUN, FLUSH, DONE) and default ADDR_W/DATA_W constants.
- One sub-module, `iir_addr_cnt`: loadable counter plus base adder producing an address. Instantiated twice (read, write).

## Test plan
- `length`=4, `base_raddr`=0x10, `base_waddr`=0x80, no stall → `raddr` 0x10..0x13 in cycles 2–5; `wen` at 0x80..0x83 in cycles 3–6 carrying `f_dout`; `done` in cycle 7.
- `length`=0 → `f_clr` in cycle 1, `done` in cycle 2, no `ren`/`wen`.
- `length`=4, `mem_wait` high in cycles 3–4 → sample 1 still written in cycle 3; remaining reads in cycles 5–7; `done` in cycle 9.
- `start` pulsed in cycles 4 and N+3 of an active frame → ignored; one frame only; `start` in cycle N+4 accepted.
- `rst` asserted in cycle 4 of an 8-sample frame → all outputs 0 immediately; no writes after; next start runs a full frame.
- `base_raddr`=0xFFFFE, `length`=4 → `raddr` 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- With `IIR_CTRL_FLUSH_EN`, `FLUSH_LEN`=5, `length`=2 → writes at `base_waddr`+0..6, last five with `f_din`=0; `done` in cycle 10.

Source files
------------

// File: rtl/iir_ctrl_pkg.sv
// Shared types and default widths for the IIR frame sequencer.
// Optional flush phase is selected with the IIR_CTRL_FLUSH_EN macro.
package iir_ctrl_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/iir_addr_cnt.sv
// Loadable address counter: captures a base address and clears its count on
// load, increments on inc_i, and presents base + count (wrapping modulo 2^ADDR_W).
module iir_addr_cnt
  import iir_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next base/count: load restarts the sequence, otherwise count up on request
  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = base_i;
      cnt_d  = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Base and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign addr_o = base_q + cnt_q;

endmodule

// File: rtl/iir_stream_ctrl.sv
// Frame sequencer for the IIR filter engine: start/busy/done protocol, reads
// samples with stall support, feeds the engine and writes its outputs.
// Define IIR_CTRL_FLUSH_EN to append FLUSH_LEN zero samples to each frame.
module iir_stream_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FLUSH_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_raddr,
  input  logic [ADDR_W-1:0] base_waddr,
  input  logic [ADDR_W-1:0] length,
  input  logic              mem_wait,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              f_clr,
  output logic              f_en,
  output logic [DATA_W-1:0] f_din,
  input  logic [DATA_W-1:0] f_dout,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              pend_q;      // a read was issued last cycle; its data is on rdata
  logic              accept;
  logic              last_wr;
  logic              wr_inc;
  logic [ADDR_W-1:0] rd_cnt, rd_addr;
  logic [ADDR_W-1:0] wr_cnt, wr_addr;

  // A flush of zero samples is meaningless; this block only exists when misconfigured
  if (FLUSH_LEN < 1) begin : g_flush_len_invalid
  end

  assign accept  = (state_q == IDLE) && start;
  assign len_d   = accept ? length : len_q;
  assign last_wr = pend_q && ((wr_cnt + ADDR_W'(1)) == len_q);

  iir_addr_cnt #(.ADDR_W(ADDR_W)) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .base_i (base_raddr),
    .inc_i  (ren),
    .cnt_o  (rd_cnt),
    .addr_o (rd_addr)
  );

  iir_addr_cnt #(.ADDR_W(ADDR_W)) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .base_i (base_waddr),
    .inc_i  (wr_inc),
    .cnt_o  (wr_cnt),
    .addr_o (wr_addr)
  );

`ifdef IIR_CTRL_FLUSH_EN
  localparam int FL_W = $clog2(FLUSH_LEN + 1);
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;

  // Flush sample counter, restarted for every frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fl_cnt_q <= '0;
    else     fl_cnt_q <= fl_cnt_d;
  end
`endif

  // Next state and all datapath controls; the return stage runs whenever a read is pending
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    f_clr   = 1'b0;
    f_en    = pend_q;
    wen     = pend_q;
    wr_inc  = pend_q;
    f_din   = pend_q ? rdata  : '0;
    wdata   = pend_q ? f_dout : '0;
`ifdef IIR_CTRL_FLUSH_EN
    fl_cnt_d = fl_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef IIR_CTRL_FLUSH_EN
        fl_cnt_d = '0;
`endif
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        f_clr   = 1'b1;
        state_d = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        ren = (rd_cnt < len_q) && !mem_wait;
        if (last_wr) begin
`ifdef IIR_CTRL_FLUSH_EN
          state_d = FLUSH;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IIR_CTRL_FLUSH_EN
      FLUSH: begin
        f_en     = 1'b1;
        wen      = 1'b1;
        wr_inc   = 1'b1;
        f_din    = '0;
        wdata    = f_dout;
        fl_cnt_d = fl_cnt_q + FL_W'(1);
        if (fl_cnt_q == FL_W'(FLUSH_LEN - 1)) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    raddr = ren ? rd_addr : '0;
    waddr = wen ? wr_addr : '0;
  end

  // State, captured length and read-pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pend_q  <= ren;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_iir_stream_ctrl.sv
// Directed, table-driven bench for iir_stream_ctrl (honours IIR_CTRL_FLUSH_EN).
module tb_iir_stream_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;
`ifdef IIR_CTRL_FLUSH_EN
  localparam int FL = 5;
`else
  localparam int FL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_raddr = '0;
  logic [AW-1:0] base_waddr = '0;
  logic [AW-1:0] length = '0;
  logic          mem_wait = 1'b0;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic          f_clr;
  logic          f_en;
  logic [DW-1:0] f_din;
  logic [DW-1:0] f_dout;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iir_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FLUSH_LEN(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_raddr (base_raddr),
    .base_waddr (base_waddr),
    .length     (length),
    .mem_wait   (mem_wait),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .f_clr      (f_clr),
    .f_en       (f_en),
    .f_din      (f_din),
    .f_dout     (f_dout),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[15:0] * 16'd3 + 16'h0107;
  endfunction

  function automatic logic [DW-1:0] eng(input logic [DW-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h1234;
  endfunction

  // Synchronous sample memory and combinational engine models
  always @(posedge clk) if (ren) rdata <= mem_val(raddr);
  assign f_dout = eng(f_din);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] br;
    logic [AW-1:0] bw;
    logic [AW-1:0] len;
    int st_lo;     // mem_wait high in cycles st_lo..st_hi
    int st_hi;
    int p1;        // extra start pulses inside the frame (0 = none)
    int p2;
    int fr;        // expected first ren cycle
    int done_cyc;  // expected done cycle without flush
    int tail;      // cycles observed after done
  } vec_t;

  vec_t vecs[10];

  task automatic run_frame(input vec_t v, input string tag);
    int c, done_at, n_done, n_fclr, fclr_at, n_busy, stall_viol, fen_mis, exp_done, exp_w;
    logic [AW-1:0] ra[$];
    int rc[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [DW-1:0] wf[$];
    int wc[$];
    logic [AW-1:0] ea;
    exp_done = v.done_cyc + ((v.len != 0) ? FL : 0);
    exp_w    = int'(v.len) + ((v.len != 0) ? FL : 0);
    done_at = -1; n_done = 0; n_fclr = 0; fclr_at = -1; n_busy = 0; stall_viol = 0; fen_mis = 0;
    @(negedge clk);
    start = 1'b1; base_raddr = v.br; base_waddr = v.bw; length = v.len; mem_wait = 1'b0;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      start    = (c == v.p1) || (c == v.p2);
      mem_wait = (c >= v.st_lo) && (c <= v.st_hi);
      #1;
      if (ren) begin ra.push_back(raddr); rc.push_back(c); if (mem_wait) stall_viol++; end
      if (wen) begin wa.push_back(waddr); wd.push_back(wdata); wf.push_back(f_din); wc.push_back(c); end
      if (f_en !== wen) fen_mis++;
      if (f_clr) begin n_fclr++; fclr_at = c; end
      if (busy) n_busy++;
      if (done) begin n_done++; if (done_at < 0) done_at = c; end
      if (done_at >= 0 && c >= done_at + v.tail) break;
      if (c >= 80) begin
        $display("FAIL %s.timeout: got no done by cycle %0d expected done at %0d", tag, c, exp_done);
        break;
      end
    end
    start = 1'b0; mem_wait = 1'b0;
    $display("frame %s: len=%0d reads=%0d writes=%0d done@%0d", tag, v.len, ra.size(), wa.size(), done_at);
    chk({tag, ".done_cycle"}, done_at, exp_done);
    chk({tag, ".done_count"}, n_done, 1);
    chk({tag, ".fclr_count"}, n_fclr, 1);
    chk({tag, ".fclr_cycle"}, fclr_at, 1);
    chk({tag, ".busy_cycles"}, n_busy, exp_done);
    chk({tag, ".ren_count"}, ra.size(), v.len);
    chk({tag, ".wen_count"}, wa.size(), exp_w);
    chk({tag, ".ren_in_stall"}, stall_viol, 0);
    chk({tag, ".fen_eq_wen"}, fen_mis, 0);
    if (rc.size() > 0) chk({tag, ".first_ren"}, rc[0], v.fr);
    for (int i = 0; i < ra.size(); i++) begin
      ea = v.br + AW'(i);
      chk($sformatf("%s.raddr%0d", tag, i), ra[i], ea);
    end
    for (int i = 0; i < wa.size(); i++) begin
      ea = v.bw + AW'(i);
      chk($sformatf("%s.waddr%0d", tag, i), wa[i], ea);
      if (i < int'(v.len)) begin
        ea = v.br + AW'(i);
        chk($sformatf("%s.fdin%0d", tag, i), wf[i], mem_val(ea));
        chk($sformatf("%s.wdata%0d", tag, i), wd[i], eng(mem_val(ea)));
        if (i < rc.size()) chk($sformatf("%s.wcyc%0d", tag, i), wc[i], rc[i] + 1);
      end else begin
        chk($sformatf("%s.flush_fdin%0d", tag, i), wf[i], 0);
        chk($sformatf("%s.flush_wdata%0d", tag, i), wd[i], eng('0));
        if (i > 0) chk($sformatf("%s.flush_cyc%0d", tag, i), wc[i], wc[i-1] + 1);
      end
    end
  endtask

  initial begin
    int n_rw;
    vecs[0] = '{20'h00010, 20'h00080, 20'd4, 0, -1, 0, 0, 2, 7, 2};
    vecs[1] = '{20'h00000, 20'h00040, 20'd0, 0, -1, 0, 0, 2, 2, 2};
    vecs[2] = '{20'h00020, 20'h00090, 20'd4, 3,  4, 0, 0, 2, 9, 2};
    vecs[3] = '{20'hFFFFE, 20'h00010, 20'd4, 0, -1, 0, 0, 2, 7, 2};
    vecs[4] = '{20'h00005, 20'hFFFFF, 20'd1, 0, -1, 0, 0, 2, 4, 2};
    vecs[5] = '{20'h00030, 20'h000A0, 20'd3, 2,  2, 0, 0, 3, 7, 2};
    vecs[6] = '{20'h00040, 20'h000B0, 20'd2, 0, -1, 0, 0, 2, 5, 2};
    vecs[7] = '{20'h00050, 20'h000C0, 20'd4, 0, -1, 4, 7, 2, 7, 2};
    vecs[8] = '{20'h00060, 20'h000D0, 20'd3, 0, -1, 0, 0, 2, 6, 0};
    vecs[9] = '{20'h00070, 20'h000E0, 20'd3, 0, -1, 0, 0, 2, 6, 2};

    // Reset state
    @(negedge clk); #1;
    chk("reset.ctrl", {26'd0, ren, wen, f_en, f_clr, busy, done}, 32'd0);
    chk("reset.raddr", raddr, 0);
    chk("reset.waddr", waddr, 0);
    chk("reset.f_din", f_din, 0);
    chk("reset.wdata", wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Abort an 8-sample frame with reset in cycle 4
    @(negedge clk);
    start = 1'b1; base_raddr = 20'h00100; base_waddr = 20'h00200; length = 20'd8;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("abort.mid_frame_wen", wen, 1);
    rst = 1'b1;
    #1;
    chk("abort.ctrl", {26'd0, ren, wen, f_en, f_clr, busy, done}, 32'd0);
    chk("abort.raddr", raddr, 0);
    chk("abort.waddr", waddr, 0);
    chk("abort.f_din", f_din, 0);
    chk("abort.wdata", wdata, 0);
    n_rw = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (ren || wen || busy) n_rw++;
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      if (ren || wen || busy) n_rw++;
    end
    chk("abort.no_activity", n_rw, 0);
    run_frame('{20'h00100, 20'h00200, 20'd8, 0, -1, 0, 0, 2, 11, 2}, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
